// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter that reads bytes from an upstream sync_fifo.
// The FIFO pop strobe is combinational. tx_o comes straight from a register.
// Optional feature: define UART_TX_PARITY_EN to add one even-parity bit after
// the data bits.
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  tx_en_i,
   input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
   input  logic                  fifo_empty_i,
   output logic                  fifo_re_o,
   output logic                  tx_o,
   output logic                  busy_o
);

   localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
   localparam int unsigned BitW  = $clog2(DATA_WIDTH);
   localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
   localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_WIDTH - 1);
   localparam logic             StopLast = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop
`ifdef UART_TX_PARITY_EN
      , StParity
`endif
   } state_e;

   state_e                state_q, state_d;
   logic [BaudW-1:0]      baud_q, baud_d;
   logic [BitW-1:0]       bit_q, bit_d;
   logic                  stop_q, stop_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
   logic                  par_q, par_d;
`endif
   logic                  launch;
   logic                  baud_end;
   logic                  re;

   assign launch   = tx_en_i & ~fifo_empty_i;
   assign baud_end = (baud_q == BaudLast);

   // Next-state, bit timing and line value; a launch preloads the start bit into tx_q.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      re      = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      if (state_q != StIdle) begin
         baud_d = baud_end ? '0 : baud_q + 1'b1;
      end
      case (state_q)
         StIdle: begin
            tx_d = 1'b1;
            if (launch) begin
               re      = 1'b1;
               shift_d = fifo_rdata_i;
`ifdef UART_TX_PARITY_EN
               par_d   = ^fifo_rdata_i;
`endif
               tx_d    = 1'b0;
               baud_d  = '0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (baud_end) begin
               bit_d   = '0;
               tx_d    = shift_q[0];
               state_d = StData;
            end
         end
         StData: begin
            if (baud_end) begin
               if (bit_q == BitLast) begin
                  bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                  tx_d    = par_q;
                  state_d = StParity;
`else
                  tx_d    = 1'b1;
                  stop_d  = 1'b0;
                  state_d = StStop;
`endif
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (baud_end) begin
               tx_d    = 1'b1;
               stop_d  = 1'b0;
               state_d = StStop;
            end
         end
`endif
         StStop: begin
            if (baud_end) begin
               if (stop_q == StopLast) begin
                  stop_d = 1'b0;
                  // Last stop cycle: chain straight into the next frame when possible.
                  if (launch) begin
                     re      = 1'b1;
                     shift_d = fifo_rdata_i;
`ifdef UART_TX_PARITY_EN
                     par_d   = ^fifo_rdata_i;
`endif
                     tx_d    = 1'b0;
                     state_d = StStart;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = StIdle;
                  end
               end else begin
                  stop_d = stop_q + 1'b1;
               end
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers; reset abandons any partial frame.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         shift_q <= '0;
         tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // Gate the pop with reset so the FIFO is never drained while reset is held.
   assign fifo_re_o = re & rst_ni;
   assign tx_o      = tx_q;
   assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: pushed bytes are queued as expected frames and
// a serial receiver model checks every bit time of tx_o against them.
module tb_uart_tx;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int NB    = 10 + P;
   localparam int FRAME = NB * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       tx_en = 1'b0;
   logic [7:0] fifo_rdata;
   logic       fifo_empty;
   logic       fifo_re;
   logic       tx;
   logic       busy;

   logic [7:0] mem [16];
   int         wr = 0;
   int         rd = 0;
   logic [7:0] sb_q [$];

   int n_checks = 0;
   int n_err    = 0;
   int pop_cnt  = 0;
   int busy_cnt = 0;
   int busy_rise = 0;
   logic busy_prev = 1'b0;

   uart_tx #(
      .CLKS_PER_BIT(CPB),
      .DATA_WIDTH  (8),
      .STOP_BITS   (1)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .tx_en_i     (tx_en),
      .fifo_rdata_i(fifo_rdata),
      .fifo_empty_i(fifo_empty),
      .fifo_re_o   (fifo_re),
      .tx_o        (tx),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   assign fifo_empty = (wr == rd);
   assign fifo_rdata = mem[rd & 15];

   always @(posedge clk) begin
      if (fifo_re) begin
         rd      <= rd + 1;
         pop_cnt <= pop_cnt + 1;
      end
   end

   always @(negedge clk) begin
      busy_cnt  <= busy_cnt + int'(busy);
      busy_prev <= busy;
      if (busy && !busy_prev) busy_rise <= busy_rise + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr & 15] = b;
      wr = wr + 1;
      sb_q.push_back(b);
   endtask

   task automatic wait_not_busy(input string name);
      int n = 0;
      while (busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_idle_timeout"}, 32'(n < 1000), 1);
   endtask

   task automatic run_single(input logic [7:0] b);
      int p0, b0;
      @(negedge clk);
      p0 = pop_cnt;
      b0 = busy_cnt;
      push(b);
      #1;
      check("launch_re", fifo_re, 1);
      @(negedge clk);
      check("start_latency_tx", tx, 0);
      check("start_latency_busy", busy, 1);
      wait_not_busy("single");
      check("single_pops", pop_cnt - p0, 1);
      check("single_busy_cycles", busy_cnt - b0, FRAME);
   endtask

   // Serial receiver model: samples every cycle, one comparison per bit time.
   initial begin : monitor
      logic [7:0]    b;
      logic [NB-1:0] bits;
      bit            abort, ok, busy_ok;
      forever begin
         @(negedge clk);
         if (rst_n && !tx) begin
            if (sb_q.size() == 0) begin
               check("unexpected_frame", 1, 0);
               continue;
            end
            b = sb_q.pop_front();
            bits = '0;
            bits[8:1] = b;
`ifdef UART_TX_PARITY_EN
            bits[9] = ^b;
`endif
            bits[NB-1] = 1'b1;
            abort = 1'b0;
            for (int j = 0; j < NB && !abort; j++) begin
               ok = 1'b1;
               busy_ok = 1'b1;
               for (int c = 0; c < CPB; c++) begin
                  if (!(j == 0 && c == 0)) @(negedge clk);
                  if (!rst_n) begin
                     abort = 1'b1;
                     break;
                  end
                  if (tx !== bits[j]) ok = 1'b0;
                  if (busy !== 1'b1) busy_ok = 1'b0;
               end
               if (!abort) begin
                  check($sformatf("frame_%02h_bit%0d", b, j), 32'(ok), 1);
                  check($sformatf("frame_%02h_busy%0d", b, j), 32'(busy_ok), 1);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      int p0, b0, r0;
      bit tx_ok, busy_ok, re_ok;
      #1 rst_n = 1'b0;
      tx_en = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_tx", tx, 1);
      check("reset_busy", busy, 0);
      check("reset_re", fifo_re, 0);
      #2 rst_n = 1'b1;
      tx_ok = 1'b1;
      busy_ok = 1'b1;
      re_ok = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) tx_ok = 1'b0;
         if (busy !== 1'b0) busy_ok = 1'b0;
         if (fifo_re !== 1'b0) re_ok = 1'b0;
      end
      check("idle_empty_tx", 32'(tx_ok), 1);
      check("idle_empty_busy", 32'(busy_ok), 1);
      check("idle_empty_re", 32'(re_ok), 1);

      // Single frames; 0xA5 has even parity 0, 0x01 has parity 1.
      run_single(8'hA5);
      run_single(8'h01);

      // Three preloaded bytes must go out as one contiguous burst.
      @(negedge clk);
      p0 = pop_cnt;
      b0 = busy_cnt;
      r0 = busy_rise;
      push(8'h00);
      push(8'hFF);
      push(8'h55);
      @(negedge clk);
      wait_not_busy("burst");
      check("burst_pops", pop_cnt - p0, 3);
      check("burst_busy_cycles", busy_cnt - b0, 3 * FRAME);
      check("burst_contiguous", busy_rise - r0, 1);

      // Dropping tx_en mid-frame lets the frame finish but blocks the next pop.
      @(negedge clk);
      p0 = pop_cnt;
      b0 = busy_cnt;
      push(8'h3C);
      push(8'h96);
      repeat (10) @(negedge clk);
      tx_en = 1'b0;
      wait_not_busy("en_drop");
      repeat (20) @(negedge clk);
      check("en_drop_pops", pop_cnt - p0, 1);
      check("en_drop_busy_cycles", busy_cnt - b0, FRAME);
      check("en_drop_tx_idle", tx, 1);
      tx_en = 1'b1;
      #1;
      check("en_raise_re", fifo_re, 1);
      @(negedge clk);
      check("en_raise_start", tx, 0);
      wait_not_busy("en_raise");
      check("en_raise_pops", pop_cnt - p0, 2);
      check("en_raise_busy_cycles", busy_cnt - b0, 2 * FRAME);

      // Asynchronous reset 15 cycles into a frame abandons it.
      @(negedge clk);
      p0 = pop_cnt;
      push(8'h5A);
      push(8'hC3);
      repeat (15) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_tx", tx, 1);
      check("async_reset_busy", busy, 0);
      check("async_reset_re", fifo_re, 0);
      repeat (3) @(negedge clk);
      check("reset_hold_pops", pop_cnt - p0, 1);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_start", tx, 0);
      wait_not_busy("post_reset");
      check("post_reset_pops", pop_cnt - p0, 2);
      check("post_reset_tx_idle", tx, 1);

      repeat (10) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that drains bytes from an upstream `sync_fifo` and emits standard asynchronous 8N1 (optionally 8E1) UART frames on a single output line. It sits between the memory-mapped UART write path (which fills the FIFO) and the chip pin. It acts as the reader end of the FIFO: it consumes the FIFO's combinational `rdata_o`, `empty_o`, and `re_i` handshake.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200 baud); legal range ≥ 2.
- `DATA_WIDTH`, default 8: data bits per frame; legal range 5..9.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.

Ports:
- `clk_i`, input, 1: single clock.
- `rst_ni`, input, 1: asynchronous, active-low reset.
- `tx_en_i`, input, 1: permits new frames to start. A frame already in progress always completes.
- `fifo_rdata_i`, input, `DATA_WIDTH`: head-of-FIFO data. Valid whenever `fifo_empty_i` is 0.
- `fifo_empty_i`, input, 1: FIFO empty flag.
- `fifo_re_o`, output, 1: pop strobe. Combinational; high for exactly one cycle per frame.
- `tx_o`, output, 1: serial line. Idles high.
- `busy_o`, output, 1: high while any frame bit (start through last stop) is on the line.

## Operation

- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- Launch condition L = `tx_en_i & ~fifo_empty_i`, evaluated in two places:
  - in IDLE;
  - in the last cycle of STOP.
- When L holds:
  - `fifo_re_o` = 1 that cycle;
  - the shift register loads `fifo_rdata_i` on the same edge;
  - the next state is START.
- Otherwise, in IDLE, or in the last cycle of STOP, `fifo_re_o` = 0, and STOP goes to IDLE.
- START: `tx_o` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: send `DATA_WIDTH` bits LSB first, each for `CLKS_PER_BIT` cycles.
  - The shift register shifts right at each bit boundary.
  - The bit index counter runs 0..`DATA_WIDTH`-1.
- PARITY: one bit time carrying the XOR of all data bits (even parity).
- STOP: `tx_o` = 1 for `STOP_BITS`×`CLKS_PER_BIT` cycles.
- Baud counter:
  - width $clog2(`CLKS_PER_BIT`);
  - counts 0..`CLKS_PER_BIT`-1 and clears at every bit boundary;
  - no wrap-around outside that range.
- `tx_o` is driven from a register. There are no combinational paths from inputs to `tx_o`.
- `busy_o` = (state ≠ IDLE).
- `tx_en_i` falling mid-frame: the frame completes, and no further pop occurs.
- FIFO becomes empty mid-frame: no effect on the current frame. Return to IDLE after STOP.
- Reset asserted mid-frame (asynchronous):
  - state goes to IDLE and counters clear;
  - `tx_o` = 1 and `busy_o` = 0 immediately;
  - the partial frame is abandoned, and no pop occurs during reset.

## Timing

- Reset values: `tx_o` = 1, `busy_o` = 0, `fifo_re_o` = 0. State is IDLE and all counters are 0.
- Pop-to-start latency: `fifo_re_o` is high in cycle N; `tx_o` falls at the edge ending cycle N (visible in cycle N+1).
- Frame length in cycles is (1 + `DATA_WIDTH` + P + `STOP_BITS`) × `CLKS_PER_BIT`, where P = 1 with parity, else 0.
- Back-to-back frames: no idle gap. The next start bit immediately follows the final stop-bit cycle.
- Start from IDLE: first start bit begins 1 cycle after `fifo_empty_i` falls (with `tx_en_i` high).

## Configuration

- Macro `UART_TX_PARITY_EN`.
- Defined: the PARITY state is compiled in, and every frame carries one even-parity bit between the last data bit and the stop bit(s).
- Undefined: no PARITY state or parity logic; DATA goes directly to STOP.

## Test plan

- Reset values: hold `rst_ni` = 0 → `tx_o` = 1, `busy_o` = 0, `fifo_re_o` = 0. Release with the FIFO empty → outputs unchanged for 100 cycles.
- Single byte 0xA5, `CLKS_PER_BIT` = 4, no parity:
  - one `fifo_re_o` pulse;
  - `tx_o` bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles;
  - `busy_o` high for exactly 40 cycles.
- Parity build, byte 0xA5 → parity bit 0. Byte 0x01 → parity bit 1. Frame is 44 cycles.
- Three bytes 0x00, 0xFF, 0x55 preloaded:
  - exactly 3 pops;
  - frames contiguous, with no high cycle between stop and next start beyond the stop bits;
  - 120 cycles total.
- `tx_en_i` dropped 10 cycles into frame 1 of 2 → frame 1 completes, then no second pop. Raising `tx_en_i` starts frame 2 one cycle later.
- `rst_ni` pulsed low at cycle 15 of a frame → `tx_o` = 1 and `busy_o` = 0 asynchronously. After release, the next queued byte is sent as a complete fresh frame.
